// File: rtl/pixel_row_packer.sv
// pixel_row_packer: packs a pixel stream into W-pixel rows through two ping-pong row buffers.
module pixel_row_packer #(
  parameter int W = 24,
  parameter int H = 24,
  parameter int DATA_BITS = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATA_BITS-1:0]   pix_data,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  output logic [W*DATA_BITS-1:0] row_data,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic                   row_last,
  output logic                   frame_done,
  output logic                   sof_err
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  localparam int RW = H > 1 ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  logic [1:0] st [2];
  logic [RW-1:0] tag [2];
  logic [W*DATA_BITS-1:0] mem [2];
  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic wr_sel, rd_sel, live;
  logic accept, xfer, sof_bad, last_col;
  always_comb begin
    accept = pix_valid & pix_ready;
    xfer = row_valid & row_ready;
    sof_bad = pix_sof & ((col != '0) | (row != '0));
    eff_col = sof_bad ? '0 : col;
    eff_row = sof_bad ? '0 : row;
    last_col = eff_col == COL_MAX;
  end
  // live holds ready low until the first edge after reset release
  assign pix_ready = live & (st[wr_sel] != FULL);
  assign row_valid = st[rd_sel] == FULL;
  assign row_data = row_valid ? mem[rd_sel] : '0;
  assign row_last = row_valid & (tag[rd_sel] == ROW_MAX);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live <= 1'b0;
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      tag[0] <= '0;
      tag[1] <= '0;
      col <= '0;
      row <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      frame_done <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      live <= 1'b1;
      frame_done <= xfer & row_last;
      sof_err <= accept & sof_bad;
      if (xfer) begin
        st[rd_sel] <= EMPTY;
        rd_sel <= ~rd_sel;
      end
      if (accept) begin
        col <= last_col ? '0 : eff_col + 1'b1;
        if (last_col) begin
          row <= (eff_row == ROW_MAX) ? '0 : eff_row + 1'b1;
          st[wr_sel] <= FULL;
          tag[wr_sel] <= eff_row;
          wr_sel <= ~wr_sel;
        end else begin
          row <= eff_row;
          st[wr_sel] <= FILLING;
        end
      end
    end
  end
  // payload needs no reset: row_data is gated by row_valid
  always_ff @(posedge clk) begin
    if (accept) mem[wr_sel][eff_col*DATA_BITS +: DATA_BITS] <= pix_data;
  end
endmodule
